// File: rtl/dm_sized_ctrl.sv
// Data memory for the MEM stage with RISC-V sized loads/stores,
// a request/response handshake and a zero-clear pass after reset.
module dm_sized_ctrl #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  size_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wd_i,
   output logic        ready_o,
   output logic        valid_o,
   output logic [31:0] rd_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      RESP
   } state_t;

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t        state_q;
   state_t        state_d;
   logic [AW-1:0] clr_q;
   logic [31:0]   rd_q;
   logic          err_q;

   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic          accept;
   logic          is_half;
   logic          is_word;
   logic          misal;
   logic          bad_size;
   logic          acc_err;
   logic          st_en;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic [31:0]   word_rd;
   logic [31:0]   shifted;
   logic [7:0]    ld_b;
   logic [15:0]   ld_h;
   logic [31:0]   ld_val;
   logic          unused_addr;

   assign idx         = addr_i[AW+1:2];
   assign off         = addr_i[1:0];
   assign unused_addr = ^addr_i[31:AW+2];

   assign is_half = (size_i[1:0] == 2'b01);
   assign is_word = (size_i[1:0] == 2'b10);
   assign misal   = (is_half & off[0]) | (is_word & (|off));

   // Stores have no unsigned variants, so size_i[2] is illegal for them.
   always_comb begin
      bad_size = 1'b0;
      if (we_i) begin
         bad_size = size_i[2] | (size_i == 3'b011);
      end else begin
         bad_size = (size_i == 3'b011) |
                    (size_i == 3'b110) |
                    (size_i == 3'b111);
      end
   end

   assign acc_err = misal | bad_size;
   assign accept  = (state_q == IDLE) & req_i;
   assign st_en   = accept & we_i & ~acc_err;

   always_comb begin
      be    = 4'b0000;
      wdata = wd_i;
      unique case (size_i[1:0])
         2'b00: begin
            be    = 4'b0001 << off;
            wdata = {4{wd_i[7:0]}};
         end
         2'b01: begin
            be    = off[1] ? 4'b1100 : 4'b0011;
            wdata = {2{wd_i[15:0]}};
         end
         2'b10: begin
            be    = 4'b1111;
            wdata = wd_i;
         end
         default: begin
            be    = 4'b0000;
            wdata = wd_i;
         end
      endcase
   end

   assign word_rd = mem[idx];
   assign shifted = word_rd >> {off, 3'b000};
   assign ld_b    = shifted[7:0];
   assign ld_h    = off[1] ? word_rd[31:16] : word_rd[15:0];

   always_comb begin
      ld_val = '0;
      unique case (size_i)
         3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
         3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
         3'b010:  ld_val = word_rd;
         3'b100:  ld_val = {24'b0, ld_b};
         3'b101:  ld_val = {16'b0, ld_h};
         default: ld_val = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (state_q == INIT) begin
         mem[clr_q] <= '0;
      end else if (st_en) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
               mem[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ready_o = 1'b0;
      valid_o = 1'b0;
      unique case (state_q)
         INIT: begin
            if (clr_q == LAST) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            ready_o = 1'b1;
            if (req_i) begin
               state_d = RESP;
            end
         end
         RESP: begin
            valid_o = 1'b1;
            state_d = IDLE;
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= INIT;
         clr_q   <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == INIT && clr_q != LAST) begin
            clr_q <= clr_q + AW'(1);
         end
         if (accept) begin
            err_q <= acc_err;
            if (acc_err) begin
               rd_q <= '0;
            end else if (!we_i) begin
               rd_q <= ld_val;
            end
         end
      end
   end

   assign rd_o  = rd_q;
   assign err_o = valid_o & err_q;

endmodule

// File: tb/tb_dm_sized_ctrl.sv
// Directed bench for dm_sized_ctrl at DEPTH=16: init pass, sized
// loads/stores, error responses, aliasing, throughput and mid-RESP reset.
module tb_dm_sized_ctrl;

   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        we;
   logic [2:0]  size;
   logic [31:0] addr;
   logic [31:0] wd;
   logic        ready;
   logic        valid;
   logic [31:0] rd;
   logic        err;

   int checks = 0;
   int errors = 0;

   dm_sized_ctrl #(.DEPTH(16)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .req_i   (req),
      .we_i    (we),
      .size_i  (size),
      .addr_i  (addr),
      .wd_i    (wd),
      .ready_o (ready),
      .valid_o (valid),
      .rd_o    (rd),
      .err_o   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_ready(output int edges);
      edges = 0;
      while (!ready && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic acc(input string tag,
                      input logic w,
                      input logic [2:0] sz,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      output logic [31:0] r,
                      output logic e);
      int n;
      wait_ready(n);
      check({tag, "_ready"}, {31'b0, ready}, 32'd1);
      we   = w;
      size = sz;
      addr = a;
      wd   = d;
      req  = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      check({tag, "_valid"}, {31'b0, valid}, 32'd1);
      r = rd;
      e = err;
      @(posedge clk);
      #1;
      check({tag, "_vdrop"}, {31'b0, valid}, 32'd0);
   endtask

   task automatic load(input string tag,
                       input logic [2:0] sz,
                       input logic [31:0] a,
                       input logic [31:0] exp_rd,
                       input logic exp_err);
      logic [31:0] r;
      logic        e;
      acc(tag, 1'b0, sz, a, 32'h0, r, e);
      check({tag, "_rd"}, r, exp_rd);
      check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
   endtask

   task automatic store(input string tag,
                        input logic [2:0] sz,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic exp_err);
      logic [31:0] r;
      logic        e;
      acc(tag, 1'b1, sz, a, d, r, e);
      check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
   endtask

   task automatic count_init(input string tag);
      int n;
      n = 0;
      while (!ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, n, 32'd16);
   endtask

   initial begin
      int pulses;
      rst_n = 1'b0;
      req   = 1'b0;
      we    = 1'b0;
      size  = 3'b000;
      addr  = '0;
      wd    = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, ready}, 32'd0);
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_rd", rd, 32'd0);

      rst_n = 1'b1;
      count_init("init_edges");

      load("lw8_init", LW, 32'h8, 32'h0, 1'b0);

      store("sw4", SW, 32'h4, 32'h87654321, 1'b0);
      load("lw4", LW, 32'h4, 32'h87654321, 1'b0);
      load("lb7", LB, 32'h7, 32'hFFFFFF87, 1'b0);
      load("lbu7", LBU, 32'h7, 32'h00000087, 1'b0);
      load("lh6", LH, 32'h6, 32'hFFFF8765, 1'b0);
      load("lhu4", LHU, 32'h4, 32'h00004321, 1'b0);

      store("sb5", SB, 32'h5, 32'h000000AA, 1'b0);
      check("store_keeps_rd", rd, 32'h00004321);
      load("lw4_sb", LW, 32'h4, 32'h8765AA21, 1'b0);
      store("sh6", SH, 32'h6, 32'h00001234, 1'b0);
      load("lw4_sh", LW, 32'h4, 32'h1234AA21, 1'b0);

      load("lw2_mis", LW, 32'h2, 32'h0, 1'b1);
      load("lw4_b", LW, 32'h4, 32'h1234AA21, 1'b0);
      load("lh3_mis", LH, 32'h3, 32'h0, 1'b1);
      load("lw4_c", LW, 32'h4, 32'h1234AA21, 1'b0);
      load("ld011", 3'b011, 32'h0, 32'h0, 1'b1);
      store("sw6_mis", SW, 32'h6, 32'hFFFFFFFF, 1'b1);
      store("st100", 3'b100, 32'h4, 32'hFFFFFFFF, 1'b1);
      load("lw4_d", LW, 32'h4, 32'h1234AA21, 1'b0);

      store("sw40", SW, 32'h40, 32'hCAFEBABE, 1'b0);
      load("lw0_alias", LW, 32'h0, 32'hCAFEBABE, 1'b0);

      we     = 1'b0;
      size   = LW;
      addr   = 32'h0;
      req    = 1'b1;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (valid) pulses++;
      end
      req = 1'b0;
      check("hold_pulses", pulses, 32'd3);
      check("hold_ready", {31'b0, ready}, 32'd1);

      we   = 1'b0;
      size = LW;
      addr = 32'h0;
      req  = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      check("resp_valid", {31'b0, valid}, 32'd1);
      check("resp_rd", rd, 32'hCAFEBABE);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'b0, valid}, 32'd0);
      check("mid_rst_rd", rd, 32'd0);
      check("mid_rst_ready", {31'b0, ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      count_init("reinit_edges");
      load("lw4_clr", LW, 32'h4, 32'h0, 1'b0);
      load("lw0_clr", LW, 32'h0, 32'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
